// File: rtl/bp_lce_req_arbiter.sv
// Round-robin arbiter that lets one of num_src_p LCE request handlers at a time
// hand a message to a one-entry buffer feeding the shared LCE request network port.
module bp_lce_req_arbiter #(
    parameter int unsigned num_src_p   = 2,
    parameter int unsigned msg_width_p = 512,
    localparam int unsigned lg_src_lp  = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [num_src_p-1:0]               src_pending_i,
    input  logic [num_src_p*msg_width_p-1:0]   src_req_i,
    input  logic [num_src_p-1:0]               src_req_v_i,
    output logic [num_src_p-1:0]               src_req_ready_then_o,
    output logic [msg_width_p-1:0]             lce_req_o,
    output logic                               lce_req_v_o,
    input  logic                               lce_req_ready_then_i,
    output logic                               grant_v_o,
    output logic [lg_src_lp-1:0]               grant_id_o,
    output logic                               error_o
);

    localparam int unsigned idx_w_lp = lg_src_lp + 1;

    logic [msg_width_p-1:0] buf_r, buf_n;
    logic                   buf_v_r, buf_v_n;
    logic                   grant_v_r, grant_v_n;
    logic [lg_src_lp-1:0]   grant_id_r, grant_id_n;
    logic [lg_src_lp-1:0]   rr_ptr_r, rr_ptr_n;
    logic                   error_r, error_n;

    logic                   space_c;
    logic [num_src_p-1:0]   ready_c;
    logic                   accept_c;
    logic                   illegal_c;
    logic                   release_c;
    logic                   arb_c;
    logic [msg_width_p-1:0] sel_msg_c;
    logic                   win_v_c;
    logic [lg_src_lp-1:0]   win_id_c;
    logic [idx_w_lp-1:0]    cand_c;
    logic [idx_w_lp-1:0]    nxt_ptr_c;

    assign lce_req_v_o = buf_v_r & lce_req_ready_then_i;
    assign space_c     = ~buf_v_r | lce_req_v_o;

    // Only the current grant holder sees ready, and only when the buffer has room
    always_comb begin : ready_gen
        ready_c   = '0;
        sel_msg_c = '0;
        for (int k = 0; k < num_src_p; k++) begin
            if (grant_id_r == lg_src_lp'(k)) begin
                ready_c[k] = grant_v_r & space_c;
                sel_msg_c  = src_req_i[k*msg_width_p +: msg_width_p];
            end
        end
    end

    assign accept_c  = |(src_req_v_i & ready_c);
    assign illegal_c = |(src_req_v_i & ~ready_c);
    assign release_c = grant_v_r & (accept_c | ~src_pending_i[grant_id_r]);
    assign arb_c     = ~grant_v_r | release_c;

    // First pending source at or after rr_ptr_r, wrapping modulo num_src_p
    always_comb begin : rr_search
        win_v_c  = 1'b0;
        win_id_c = '0;
        cand_c   = '0;
        for (int i = 0; i < num_src_p; i++) begin
            cand_c = {1'b0, rr_ptr_r} + idx_w_lp'(i);
            if (cand_c >= idx_w_lp'(num_src_p)) begin
                cand_c = cand_c - idx_w_lp'(num_src_p);
            end
            if (!win_v_c && src_pending_i[cand_c[lg_src_lp-1:0]]) begin
                win_v_c  = 1'b1;
                win_id_c = cand_c[lg_src_lp-1:0];
            end
        end
        nxt_ptr_c = {1'b0, win_id_c} + idx_w_lp'(1);
        if (nxt_ptr_c >= idx_w_lp'(num_src_p)) begin
            nxt_ptr_c = nxt_ptr_c - idx_w_lp'(num_src_p);
        end
    end

    always_comb begin : next_state
        buf_n      = buf_r;
        buf_v_n    = buf_v_r;
        grant_v_n  = grant_v_r;
        grant_id_n = grant_id_r;
        rr_ptr_n   = rr_ptr_r;
        error_n    = error_r | illegal_c;

        // A new message wins over the drain of the old one
        if (accept_c) begin
            buf_n   = sel_msg_c;
            buf_v_n = 1'b1;
        end else if (lce_req_v_o) begin
            buf_v_n = 1'b0;
        end

        if (arb_c) begin
            if (win_v_c) begin
                grant_v_n  = 1'b1;
                grant_id_n = win_id_c;
                rr_ptr_n   = nxt_ptr_c[lg_src_lp-1:0];
            end else begin
                grant_v_n  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin : state_reg
        if (reset_i) begin
            buf_r      <= '0;
            buf_v_r    <= 1'b0;
            grant_v_r  <= 1'b0;
            grant_id_r <= '0;
            rr_ptr_r   <= '0;
            error_r    <= 1'b0;
        end else begin
            buf_r      <= buf_n;
            buf_v_r    <= buf_v_n;
            grant_v_r  <= grant_v_n;
            grant_id_r <= grant_id_n;
            rr_ptr_r   <= rr_ptr_n;
            error_r    <= error_n;
        end
    end

    assign src_req_ready_then_o = ready_c;
    assign lce_req_o            = buf_r;
    assign grant_v_o            = grant_v_r;
    assign grant_id_o           = grant_id_r;
    assign error_o              = error_r;

endmodule

// File: tb/tb_bp_lce_req_arbiter.sv
// Bench for bp_lce_req_arbiter: a queue/integer-level reference of the arbiter rules
// checked every cycle, plus directed scenarios with literal expectations.
module tb_bp_lce_req_arbiter;

    localparam int N = 2;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset_i;
    logic [N-1:0]   src_pending_i;
    logic [N*W-1:0] src_req_i;
    logic [N-1:0]   src_req_v_i;
    logic [N-1:0]   src_req_ready_then_o;
    logic [W-1:0]   lce_req_o;
    logic           lce_req_v_o;
    logic           lce_req_ready_then_i;
    logic           grant_v_o;
    logic [0:0]     grant_id_o;
    logic           error_o;

    bp_lce_req_arbiter #(.num_src_p(N), .msg_width_p(W)) dut (
        .clk_i                (clk),
        .reset_i              (reset_i),
        .src_pending_i        (src_pending_i),
        .src_req_i            (src_req_i),
        .src_req_v_i          (src_req_v_i),
        .src_req_ready_then_o (src_req_ready_then_o),
        .lce_req_o            (lce_req_o),
        .lce_req_v_o          (lce_req_v_o),
        .lce_req_ready_then_i (lce_req_ready_then_i),
        .grant_v_o            (grant_v_o),
        .grant_id_o           (grant_id_o),
        .error_o              (error_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: holder index (or none), rotating start point, a 0/1-entry queue, sticky error
    bit           m_holds;
    int           m_holder;
    int           m_start;
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_last;
    bit           m_err;

    function automatic bit m_may_send(int k);
        return m_holds && (m_holder == k) && (m_q.size() == 0 || lce_req_ready_then_i);
    endfunction

    bit m_acc, m_rel;
    int m_acc_k;
    always @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            m_holds = 0; m_holder = 0; m_start = 0; m_q.delete(); m_last = '0; m_err = 0;
        end else begin
            m_acc = 0; m_acc_k = 0;
            for (int k = 0; k < N; k++) begin
                if (src_req_v_i[k] && m_may_send(k)) begin m_acc = 1; m_acc_k = k; end
                else if (src_req_v_i[k]) m_err = 1;
            end
            m_rel = m_holds && (m_acc || !src_pending_i[m_holder]);
            if (m_q.size() != 0 && lce_req_ready_then_i) void'(m_q.pop_front());
            if (m_acc) begin
                m_last = src_req_i[m_acc_k*W +: W];
                m_q.push_back(m_last);
            end
            if (!m_holds || m_rel) begin
                m_holds = 0;
                for (int i = 0; i < N; i++) begin
                    if (!m_holds && src_pending_i[(m_start + i) % N]) begin
                        m_holds  = 1;
                        m_holder = (m_start + i) % N;
                    end
                end
                if (m_holds) m_start = (m_holder + 1) % N;
            end
        end
    end

    // Cycle-by-cycle comparison against the reference
    logic [N-1:0] exp_rdy;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < N; k++) exp_rdy[k] = m_may_send(k);
            check("m_lce_req_o", 64'(lce_req_o), 64'(m_last));
            check("m_lce_req_v_o", 64'(lce_req_v_o), 64'((m_q.size() != 0) && lce_req_ready_then_i));
            check("m_ready_then", 64'(src_req_ready_then_o), 64'(exp_rdy));
            check("m_grant_v", 64'(grant_v_o), 64'(m_holds));
            check("m_grant_id", 64'(grant_id_o), 64'(m_holder));
            check("m_error", 64'(error_o), 64'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int c0, c1;
    int gid_hist[20];

    initial begin
        reset_i = 1'b0; src_pending_i = '0; src_req_i = '0; src_req_v_i = '0;
        lce_req_ready_then_i = 1'b1;
        #1 reset_i = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_grant_v", 64'(grant_v_o), 64'd0);
        check("rst_error", 64'(error_o), 64'd0);
        check("rst_lce_v", 64'(lce_req_v_o), 64'd0);
        check("rst_lce_req", 64'(lce_req_o), 64'd0);
        cyc(); cyc();
        reset_i = 1'b0;

        // Single source: pending -> grant -> send 0xA5 -> on the network
        src_pending_i = 2'b01;
        @(negedge clk); check("ss_no_grant_yet", 64'(grant_v_o), 64'd0);
        cyc();
        src_req_v_i = 2'b01; src_req_i = {32'h0, 32'hA5};
        @(negedge clk);
        check("ss_grant_v", 64'(grant_v_o), 64'd1);
        check("ss_grant_id", 64'(grant_id_o), 64'd0);
        check("ss_ready", 64'(src_req_ready_then_o), 64'h1);
        cyc();
        src_req_v_i = '0; src_pending_i = '0;
        @(negedge clk);
        check("ss_lce_v", 64'(lce_req_v_o), 64'd1);
        check("ss_lce_req", 64'(lce_req_o), 64'hA5);
        cyc();

        // Fairness: both pending, each sends as soon as it is ready
        src_pending_i = 2'b11; c0 = 0; c1 = 0;
        for (int i = 0; i < 20; i++) begin
            src_req_i = {32'h2000_0000 + 32'(i), 32'h1000_0000 + 32'(i)};
            src_req_v_i = src_req_ready_then_o;
            if (src_req_v_i[0]) c0++;
            if (src_req_v_i[1]) c1++;
            gid_hist[i] = grant_v_o ? int'(grant_id_o) : -1;
            cyc();
        end
        src_req_v_i = '0; src_pending_i = '0;
        check("fair_first_winner", 64'(gid_hist[1]), 64'd1);
        for (int i = 2; i < 20; i++)
            check("fair_alternate", 64'(gid_hist[i]), 64'(1 - gid_hist[i-1]));
        check("fair_balance", 64'((c0 > c1 ? c0 - c1 : c1 - c0) <= 1), 64'd1);
        check("fair_throughput", 64'((c0 + c1) >= 10), 64'd1);
        cyc(); cyc();

        // Back-pressure: full buffer and a stalled network blocks every source
        lce_req_ready_then_i = 1'b0; src_pending_i = 2'b01;
        cyc();
        src_req_v_i = 2'b01; src_req_i = {32'h0, 32'hBEEF};
        @(negedge clk); check("bp_ready_first", 64'(src_req_ready_then_o), 64'h1);
        cyc();
        src_req_v_i = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ready_blocked", 64'(src_req_ready_then_o), 64'h0);
            check("bp_lce_v_low", 64'(lce_req_v_o), 64'd0);
            check("bp_grant_held", 64'(grant_v_o), 64'd1);
            cyc();
        end
        lce_req_ready_then_i = 1'b1; src_req_i = {32'h0, 32'hCAFE};
        #1;
        src_req_v_i = src_req_ready_then_o;
        @(negedge clk);
        check("bp_drain_v", 64'(lce_req_v_o), 64'd1);
        check("bp_drain_msg", 64'(lce_req_o), 64'hBEEF);
        check("bp_same_cycle_ready", 64'(src_req_ready_then_o), 64'h1);
        cyc();
        src_req_v_i = '0;
        @(negedge clk);
        check("bp_next_msg", 64'(lce_req_o), 64'hCAFE);
        cyc();

        // Withdraw: holder 0 drops its request, source 1 takes over with nothing sent
        src_pending_i = 2'b10;
        @(negedge clk);
        check("wd_holder0", 64'(grant_id_o), 64'd0);
        check("wd_no_msg0", 64'(lce_req_v_o), 64'd0);
        cyc();
        @(negedge clk);
        check("wd_holder1", 64'(grant_id_o), 64'd1);
        check("wd_grant_v", 64'(grant_v_o), 64'd1);
        check("wd_no_msg1", 64'(lce_req_v_o), 64'd0);

        // Protocol error: source 1 sends while source 0 holds the grant
        src_pending_i = 2'b01;
        cyc();
        src_req_v_i = 2'b10; src_req_i = {32'hDEAD, 32'h0};
        @(negedge clk);
        check("pe_error_before", 64'(error_o), 64'd0);
        check("pe_ready", 64'(src_req_ready_then_o), 64'h1);
        cyc();
        src_req_v_i = '0;
        @(negedge clk);
        check("pe_error_set", 64'(error_o), 64'd1);
        check("pe_not_buffered", 64'(lce_req_v_o), 64'd0);
        check("pe_buf_unchanged", 64'(lce_req_o), 64'hCAFE);
        cyc(); cyc();
        @(negedge clk); check("pe_error_sticky", 64'(error_o), 64'd1);

        // Async reset while a message sits in the buffer
        lce_req_ready_then_i = 1'b0; src_req_v_i = 2'b01; src_req_i = {32'h0, 32'h77};
        cyc();
        src_req_v_i = '0;
        @(negedge clk);
        check("ar_buffered", 64'(lce_req_o), 64'h77);
        check("ar_stalled", 64'(lce_req_v_o), 64'd0);
        cyc();
        lce_req_ready_then_i = 1'b1;
        #1 check("ar_v_before", 64'(lce_req_v_o), 64'd1);
        #1 reset_i = 1'b1;
        #1;
        check("ar_lce_v", 64'(lce_req_v_o), 64'd0);
        check("ar_grant_v", 64'(grant_v_o), 64'd0);
        check("ar_error", 64'(error_o), 64'd0);
        check("ar_lce_req", 64'(lce_req_o), 64'd0);
        cyc();
        reset_i = 1'b0; src_pending_i = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ar_never_sent", 64'(lce_req_v_o), 64'd0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
